timer_tick_sequencer: RTL and testbench
=======================================

Name: timer_tick_sequencer

Overview:
- Control stage directly upstream of the simple down-counter timer.
- Arms on command and waits for a synchronized external trigger edge.
- Then loads the counter: a one-cycle start pulse with preset N.
- Paces the countdown with a programmable prescaled tick, watches the counter's expired flag, and reports completion, run count and state to the register bank.

Parameters:
- PRESCALE_W, 16, width of prescaler period field.
- CNT_W, 32, width of preset count (matches counter N port).
- RUNS_W, 16, width of completed-run counter.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- cfg_prescale  in  PRESCALE_W  tick period minus 1 (tick every cfg_prescale+1 cycles).
- cfg_n  in  CNT_W  preset count for the counter.
- cfg_retrigger  in  1  1: re-arm automatically after completion.
- arm  in  1  single-cycle arm request.
- abort  in  1  single-cycle abort request.
- trig_in  in  1  asynchronous external trigger level.
- expired_in  in  1  counter reached zero (counter overflow[1]).
- start  out  1  counter load pulse.
- timer_tick  out  1  counter decrement strobe.
- n_out  out  CNT_W  preset value driven to the counter N input.
- busy  out  1  state != IDLE.
- done  out  1  single-cycle completion pulse.
- run_count  out  RUNS_W  completed runs, saturating.
- state_o  out  2  current FSM state code.

Behaviour:
- Reset (async, rstn=0): state IDLE; start, timer_tick, busy, done 0; n_out 0; run_count 0; prescaler 0; synchronizer flops s1, s2, s3 cleared; latched config 0. Takes effect immediately, including mid-run.
- Trigger path: s1 <= trig_in, s2 <= s1, s3 <= s2. trig_edge = s2 & ~s3.
  - trig_in first sampled high at edge k gives trig_edge high during the cycle after edge k+1.
  - Synchronizer runs in all states; edges outside ARMED are discarded. A trig_in already high at reset deasserts yields one edge ~2 cycles later (ignored unless already ARMED).
- FSM codes: IDLE=0, ARMED=1, LOAD=2, RUN=3.
- IDLE:
  - arm & ~abort -> ARMED.
  - arm and abort in the same cycle -> stay IDLE.
- ARMED:
  - abort -> IDLE.
  - else trig_edge -> LOAD. On this transition, latch cfg_n into n_out and cfg_prescale into p_lat.
- LOAD (exactly one cycle):
  - start=1; prescaler cleared.
  - -> RUN unconditionally; abort in LOAD -> IDLE, start still asserted that cycle.
- RUN:
  - Prescaler pre_cnt counts 0..p_lat and wraps to 0.
  - timer_tick = (state==RUN) & (pre_cnt==p_lat) & ~expired_in & ~abort (combinational from registered state).
  - First tick in the (p_lat+1)-th RUN cycle. p_lat=0 gives a tick every RUN cycle.
  - expired_in is valid from the first RUN cycle (counter loads at the end of LOAD).
  - abort (priority over expired) -> IDLE: no done, run_count unchanged, no tick that cycle.
  - else expired_in=1 -> done=1 next cycle (registered); run_count += 1, saturating at all-ones; next state ARMED if cfg_retrigger else IDLE.
- arm in any state other than IDLE is ignored.
- cfg_* changes outside the ARMED->LOAD transition have no effect on the run in progress.
- n_out holds its last latched value until the next trigger.

Test Plan:
- cfg_prescale=3, cfg_n=5, arm, trig_in rises at edge k:
  - start=1 in the cycle after edge k+2.
  - Exactly 5 timer_tick pulses, 4 cycles apart; first in the 4th RUN cycle.
  - done one cycle after expired_in; run_count=1; state_o=0, busy=0.
- cfg_prescale=0, cfg_n=0: arm+trigger -> start, expired_in high in first RUN cycle -> zero ticks, done pulse, run_count=1.
- cfg_retrigger=1, cfg_n=2, two trigger edges -> two complete runs, run_count=2, state_o=1 (ARMED) at end; abort -> IDLE.
- cfg_n=10, cfg_prescale=1: abort after 2 ticks -> timer_tick 0 from the abort cycle, state IDLE, no done, run_count unchanged.
- Trigger edge while IDLE -> no start. arm+abort in the same cycle -> stays IDLE. cfg_n changed to 99 mid-RUN -> n_out unchanged, tick total equals the original N.
- rstn pulled low mid-RUN (between clock edges) -> all outputs 0 immediately. After release, trig_in held high produces no start without a new arm.

Source files
------------

// File: rtl/timer_tick_sequencer.sv
// Arms on command, waits for a synchronized trigger edge, loads the down-counter,
// then paces it with a prescaled tick and reports completion to the register bank.
module timer_tick_sequencer #(
  parameter int PRESCALE_W = 16,
  parameter int CNT_W      = 32,
  parameter int RUNS_W     = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [PRESCALE_W-1:0] cfg_prescale,
  input  logic [CNT_W-1:0]      cfg_n,
  input  logic                  cfg_retrigger,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  trig_in,
  input  logic                  expired_in,
  output logic                  start,
  output logic                  timer_tick,
  output logic [CNT_W-1:0]      n_out,
  output logic                  busy,
  output logic                  done,
  output logic [RUNS_W-1:0]     run_count,
  output logic [1:0]            state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    LOAD  = 2'd2,
    RUN   = 2'd3
  } state_t;

  state_t                state_reg, state_next;
  logic                  s1_reg, s2_reg, s3_reg;
  logic                  trig_edge;
  logic [PRESCALE_W-1:0] p_lat_reg;
  logic [PRESCALE_W-1:0] pre_cnt_reg;
  logic [CNT_W-1:0]      n_reg;
  logic                  retrig_reg;
  logic                  done_reg;
  logic [RUNS_W-1:0]     runs_reg;
  logic                  load_cfg;
  logic                  complete;

  // Three-flop chain: two for metastability, the third for rising-edge detect.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
      s3_reg <= 1'b0;
    end else begin
      s1_reg <= trig_in;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
    end
  end

  assign trig_edge = s2_reg & ~s3_reg;

  always_comb begin
    state_next = state_reg;
    load_cfg   = 1'b0;
    complete   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (arm && !abort) state_next = ARMED;
      end
      ARMED: begin
        if (abort) begin
          state_next = IDLE;
        end else if (trig_edge) begin
          state_next = LOAD;
          load_cfg   = 1'b1;
        end
      end
      LOAD: begin
        state_next = abort ? IDLE : RUN;
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (expired_in) begin
          complete   = 1'b1;
          state_next = retrig_reg ? ARMED : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= IDLE;
      p_lat_reg   <= '0;
      pre_cnt_reg <= '0;
      n_reg       <= '0;
      retrig_reg  <= 1'b0;
      done_reg    <= 1'b0;
      runs_reg    <= '0;
    end else begin
      state_reg <= state_next;
      done_reg  <= complete;
      // Config is sampled only as the trigger fires, so later edits never disturb a run.
      if (load_cfg) begin
        n_reg      <= cfg_n;
        p_lat_reg  <= cfg_prescale;
        retrig_reg <= cfg_retrigger;
      end
      if (state_reg == RUN) begin
        pre_cnt_reg <= (pre_cnt_reg == p_lat_reg) ? '0 : pre_cnt_reg + PRESCALE_W'(1);
      end else begin
        pre_cnt_reg <= '0;
      end
      if (complete && (runs_reg != '1)) begin
        runs_reg <= runs_reg + RUNS_W'(1);
      end
    end
  end

  assign start      = (state_reg == LOAD);
  assign timer_tick = (state_reg == RUN) && (pre_cnt_reg == p_lat_reg) && !expired_in && !abort;
  assign busy       = (state_reg != IDLE);
  assign done       = done_reg;
  assign n_out      = n_reg;
  assign run_count  = runs_reg;
  assign state_o    = state_reg;

endmodule

// File: tb/tb_timer_tick_sequencer.sv
// Bench for timer_tick_sequencer: a behavioural down-counter closes the loop and
// expected tick positions, latencies and run counts are derived arithmetically.
module tb_timer_tick_sequencer;

  localparam int PW = 16;
  localparam int CW = 32;
  localparam int RW = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [PW-1:0] cfg_prescale = '0;
  logic [CW-1:0] cfg_n = '0;
  logic          cfg_retrigger = 1'b0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic          trig_in = 1'b0;
  logic          expired_in;
  logic          start, timer_tick, busy, done;
  logic [CW-1:0] n_out;
  logic [RW-1:0] run_count;
  logic [1:0]    state_o;

  int total = 0;
  int bad = 0;
  int exp_runs = 0;
  logic [CW-1:0] cnt;

  timer_tick_sequencer #(.PRESCALE_W(PW), .CNT_W(CW), .RUNS_W(RW)) dut (
    .clk(clk), .rstn(rstn), .cfg_prescale(cfg_prescale), .cfg_n(cfg_n),
    .cfg_retrigger(cfg_retrigger), .arm(arm), .abort(abort), .trig_in(trig_in),
    .expired_in(expired_in), .start(start), .timer_tick(timer_tick), .n_out(n_out),
    .busy(busy), .done(done), .run_count(run_count), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Downstream counter: loads on start, decrements per tick, flags zero.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) cnt <= '0;
    else if (start) cnt <= n_out;
    else if (timer_tick && cnt != 0) cnt <= cnt - 1;
  end
  assign expired_in = (cnt == 0);

  task automatic chk(input string tag, input longint obs, input longint expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_run(input int p, input int n, input bit retrig, input bit do_arm,
                        input int abort_r, input bit chg_cfg, input bit rst_mid);
    int w, ticks, done_r, limit;
    bit seen;
    cyc();
    cfg_prescale = PW'(p); cfg_n = CW'(n); cfg_retrigger = retrig; arm = do_arm;
    cyc();
    arm = 1'b0; trig_in = 1'b1;
    @(negedge clk);
    chk("armed", state_o, 1);
    w = 1; seen = 0;
    while (!seen && w < 10) begin
      if (start) seen = 1;
      else begin cyc(); @(negedge clk); w++; end
    end
    chk("start_latency", w, 4);
    chk("n_latch", n_out, n);
    ticks = 0; done_r = 0; limit = n * (p + 1) + 10;
    for (int r = 1; r <= limit; r++) begin
      cyc();
      trig_in = 1'b0;
      abort = (r == abort_r);
      if (chg_cfg && r == 2) begin cfg_n = 99; cfg_prescale = PW'(p + 5); end
      @(negedge clk);
      if (r == 1) chk("run_state", state_o, 3);
      if (timer_tick) begin ticks++; chk("tick_pos", r, ticks * (p + 1)); end
      if (chg_cfg && r == 3) chk("n_hold", n_out, n);
      if (r == abort_r) chk("abort_tick", timer_tick, 0);
      if (rst_mid && r == 3) begin
        #2 rstn = 1'b0;
        #1;
        chk("rst_start", start, 0);
        chk("rst_tick", timer_tick, 0);
        chk("rst_busy", busy, 0);
        chk("rst_n_out", n_out, 0);
        chk("rst_runs", run_count, 0);
        chk("rst_state", state_o, 0);
        exp_runs = 0;
        break;
      end
      if (done) begin done_r = r; break; end
      if (abort_r != 0 && r == abort_r + 3) break;
    end
    abort = 1'b0;
    if (rst_mid) return;
    if (abort_r == 0) begin
      exp_runs = (exp_runs < 65535) ? exp_runs + 1 : exp_runs;
      chk("ticks", ticks, n);
      chk("done_cycle", done_r, n * (p + 1) + 2);
      chk("run_count", run_count, exp_runs);
      chk("end_state", state_o, retrig ? 1 : 0);
      chk("end_busy", busy, retrig ? 1 : 0);
      cyc(); @(negedge clk);
      chk("done_width", done, 0);
    end else begin
      chk("abort_nodone", done_r, 0);
      chk("abort_state", state_o, 0);
      chk("abort_runs", run_count, exp_runs);
      chk("abort_ticks", ticks, (abort_r - 1) / (p + 1));
    end
  endtask

  initial begin
    int starts;
    repeat (3) cyc();
    @(negedge clk);
    chk("reset_state", state_o, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_runs", run_count, 0);
    chk("reset_n_out", n_out, 0);
    cyc(); rstn = 1'b1;
    repeat (2) cyc();

    do_run(3, 5, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    do_run(0, 0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    do_run(1, 2, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    do_run(1, 2, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    chk("retrig_runs", run_count, 4);
    cyc(); abort = 1'b1;
    cyc(); abort = 1'b0;
    @(negedge clk);
    chk("armed_abort", state_o, 0);

    // Trigger edge while idle must not start anything.
    repeat (4) cyc();
    trig_in = 1'b1; starts = 0;
    for (int i = 0; i < 6; i++) begin cyc(); @(negedge clk); if (start) starts++; end
    chk("idle_trig_starts", starts, 0);
    chk("idle_trig_state", state_o, 0);
    trig_in = 1'b0;
    repeat (4) cyc();

    arm = 1'b1; abort = 1'b1;
    cyc(); arm = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("arm_abort_state", state_o, 0);

    do_run(1, 10, 1'b0, 1'b1, 6, 1'b0, 1'b0);
    do_run(2, 4, 1'b0, 1'b1, 0, 1'b1, 1'b0);

    for (int i = 0; i < 6; i++) begin
      do_run(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), 1'b0, 1'b1, 0, 1'b0, 1'b0);
    end

    do_run(1, 8, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    trig_in = 1'b1;
    #3 rstn = 1'b1;
    starts = 0;
    for (int i = 0; i < 8; i++) begin cyc(); @(negedge clk); if (start) starts++; end
    chk("post_rst_starts", starts, 0);
    chk("post_rst_state", state_o, 0);
    chk("post_rst_runs", run_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
